// File: rtl/frame_scheduler.sv
// Frame job scheduler: walks one frame in raster order, offers each pixel to the
// next ready solver round-robin, and counts write-backs until the frame is complete.
module frame_scheduler #(
  parameter int NUM_SOLVERS = 2,
  parameter int COORD_W     = 11
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [COORD_W-1:0]     cfg_width_i,
  input  logic [COORD_W-1:0]     cfg_height_i,
  input  logic [31:0]            cfg_base_i,
  output logic [NUM_SOLVERS-1:0] job_valid_o,
  input  logic [NUM_SOLVERS-1:0] job_ready_i,
  output logic [COORD_W-1:0]     job_x_o,
  output logic [COORD_W-1:0]     job_y_o,
  output logic [31:0]            job_addr_o,
  input  logic                   pix_done_i,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic                   err_spurious_o
);
  localparam int RR_W  = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam int CNT_W = 2 * COORD_W;

  typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_DRAIN, ST_DONE} state_t;
  state_t state_q, state_d;

  logic [COORD_W-1:0]     width_q, width_d, x_q, x_d, y_q, y_d;
  logic [31:0]            addr_q, addr_d;
  logic [CNT_W-1:0]       total_q, total_d, disp_q, disp_d, comp_q, comp_d;
  logic [NUM_SOLVERS-1:0] valid_q, valid_d;
  logic [RR_W-1:0]        rr_q, rr_d, tgt_q, tgt_d;
  logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic                     start_acc, xfer, pick_found;
  logic [2*NUM_SOLVERS-1:0] ready_rot;
  logic [RR_W-1:0]          pick_off, pick_idx;
  logic [RR_W:0]            pick_sum;

  // busy_q covers the frame_done cycle, so a start in that cycle is refused.
  assign start_acc = start_i && (state_q == ST_IDLE) && !busy_q;
  assign xfer      = |(valid_q & job_ready_i);

  // Rotating the ready vector by rr_q turns the wrapping search into a lowest-bit search.
  assign ready_rot = {job_ready_i, job_ready_i} >> rr_q;

  always_comb begin
    pick_found = 1'b0;
    pick_off   = '0;
    for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
      if (ready_rot[i]) begin
        pick_found = 1'b1;
        pick_off   = RR_W'(i);
      end
    end
    pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
    if (pick_sum >= (RR_W+1)'(NUM_SOLVERS)) begin
      pick_sum = pick_sum - (RR_W+1)'(NUM_SOLVERS);
    end
    pick_idx = pick_sum[RR_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d = (cfg_width_i == '0 || cfg_height_i == '0) ? ST_DONE : ST_DISPATCH;
        end
      end
      ST_DISPATCH: if (xfer && (disp_q + CNT_W'(1) == total_q)) state_d = ST_DRAIN;
      ST_DRAIN:    if (comp_q == total_q) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    width_d = width_q;
    total_d = total_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    disp_d  = disp_q;
    comp_d  = comp_q;
    valid_d = valid_q;
    rr_d    = rr_q;
    tgt_d   = tgt_q;
    err_d   = err_q;

    if (state_q == ST_DISPATCH) begin
      if (valid_q != '0) begin
        if (xfer) begin
          valid_d = '0;
          rr_d    = (tgt_q == RR_W'(NUM_SOLVERS - 1)) ? '0 : tgt_q + RR_W'(1);
          disp_d  = disp_q + CNT_W'(1);
          addr_d  = addr_q + 32'd2;
          if (x_q == width_q - COORD_W'(1)) begin
            x_d = '0;
            y_d = y_q + COORD_W'(1);
          end else begin
            x_d = x_q + COORD_W'(1);
          end
        end
      end else if (pick_found) begin
        tgt_d = pick_idx;
        for (int i = 0; i < NUM_SOLVERS; i++) begin
          valid_d[i] = (pick_idx == RR_W'(i));
        end
      end
    end

    // A transfer in the same cycle makes that pixel eligible for completion.
    if (pix_done_i) begin
      if (comp_q < disp_q + CNT_W'(xfer)) comp_d = comp_q + CNT_W'(1);
      else                                err_d  = 1'b1;
    end

    if (start_acc) begin
      width_d = cfg_width_i;
      total_d = CNT_W'(cfg_width_i) * CNT_W'(cfg_height_i);
      x_d     = '0;
      y_d     = '0;
      addr_d  = cfg_base_i;
      disp_d  = '0;
      comp_d  = '0;
      valid_d = '0;
    end

    busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      width_q <= '0;
      total_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      disp_q  <= '0;
      comp_q  <= '0;
      valid_q <= '0;
      rr_q    <= '0;
      tgt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      width_q <= width_d;
      total_q <= total_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      disp_q  <= disp_d;
      comp_q  <= comp_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign job_valid_o    = valid_q;
  assign job_x_o        = x_q;
  assign job_y_o        = y_q;
  assign job_addr_o     = addr_q;
  assign busy_o         = busy_q;
  assign frame_done_o   = done_q;
  assign err_spurious_o = err_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: dispatch order, offer hold, empty frame,
// async reset, spurious completion flag and start-while-busy.
module tb_frame_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] cfg_w, cfg_h;
  logic [31:0] cfg_base;
  logic [1:0]  job_valid, job_ready;
  logic [10:0] job_x, job_y;
  logic [31:0] job_addr;
  logic        pix_done, busy, frame_done, err_spurious;

  int checks = 0;
  int failures = 0;

  logic [1:0]  obs_v [32];
  logic [10:0] obs_x [32];
  logic [10:0] obs_y [32];
  logic [31:0] obs_a [32];

  always #5 clk = ~clk;

  frame_scheduler #(.NUM_SOLVERS(2), .COORD_W(11)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .cfg_width_i(cfg_w), .cfg_height_i(cfg_h), .cfg_base_i(cfg_base),
    .job_valid_o(job_valid), .job_ready_i(job_ready),
    .job_x_o(job_x), .job_y_o(job_y), .job_addr_o(job_addr),
    .pix_done_i(pix_done), .busy_o(busy), .frame_done_o(frame_done),
    .err_spurious_o(err_spurious)
  );

  task automatic start_frame(input logic [10:0] w, input logic [10:0] h, input logic [31:0] base);
    @(negedge clk);
    cfg_w = w; cfg_h = h; cfg_base = base; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Serves a running frame: holds job_ready, logs every accepted offer and answers
  // each with pix_done three cycles later; returns one cycle after frame_done.
  task automatic drain_frame(input logic [1:0] rdy, input int npix,
                             output int njobs, output int nfd, output int early, output int err_all);
    int pd_due[$];
    int pd_sent;
    bit fin;
    njobs = 0; nfd = 0; early = 0; err_all = 1; pd_sent = 0; fin = 1'b0;
    job_ready = rdy;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (err_spurious !== 1'b1) err_all = 0;
      if (frame_done === 1'b1) begin
        nfd++;
        if (pd_sent < npix) early++;
        fin = 1'b1;
      end
      if (|(job_valid & rdy)) begin
        if (njobs < 32) begin
          obs_v[njobs] = job_valid; obs_x[njobs] = job_x;
          obs_y[njobs] = job_y;     obs_a[njobs] = job_addr;
        end
        njobs++;
        pd_due.push_back(c + 3);
      end
      if (pd_due.size() > 0 && pd_due[0] == c) begin
        pix_done = 1'b1;
        void'(pd_due.pop_front());
        pd_sent++;
      end else begin
        pix_done = 1'b0;
      end
      @(negedge clk);
    end
    pix_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cfg_w = '0; cfg_h = '0; cfg_base = '0;
    job_ready = 2'b00; pix_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({job_valid, job_x, job_y, job_addr, busy, frame_done, err_spurious} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b x=%0d y=%0d a=%h busy=%b fd=%b err=%b want all 0",
               job_valid, job_x, job_y, job_addr, busy, frame_done, err_spurious);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({job_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle got v=%b busy=%b want v=00 busy=0", job_valid, busy);
    end
  endtask

  task automatic test_basic_frame();
    logic [55:0] exp_j [4];
    int nj, nf, er, ea;
    exp_j[0] = {2'b01, 11'd0, 11'd0, 32'h1000};
    exp_j[1] = {2'b10, 11'd1, 11'd0, 32'h1002};
    exp_j[2] = {2'b01, 11'd0, 11'd1, 32'h1004};
    exp_j[3] = {2'b10, 11'd1, 11'd1, 32'h1006};
    job_ready = 2'b11;
    start_frame(11'd2, 11'd2, 32'h1000);
    drain_frame(2'b11, 4, nj, nf, er, ea);
    checks++;
    if (nj !== 4) begin failures++; $display("FAIL basic_job_count got %0d want 4", nj); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if ({obs_v[j], obs_x[j], obs_y[j], obs_a[j]} !== exp_j[j]) begin
        failures++;
        $display("FAIL basic_job%0d got v=%b x=%0d y=%0d a=%h want %h", j,
                 obs_v[j], obs_x[j], obs_y[j], obs_a[j], exp_j[j]);
      end
    end
    checks++;
    if (nf !== 1 || er !== 0) begin
      failures++;
      $display("FAIL basic_frame_done got pulses=%0d early=%0d want 1 and 0", nf, er);
    end
    checks++;
    if ({busy, frame_done} !== 2'b00) begin
      failures++;
      $display("FAIL basic_after_done got busy=%b fd=%b want 0 0", busy, frame_done);
    end
  endtask

  task automatic test_offer_hold();
    int nj, nf, er, ea;
    job_ready = 2'b10;
    start_frame(11'd2, 11'd1, 32'h2000);
    @(negedge clk);
    checks++;
    if ({job_valid, job_x, job_y, job_addr} !== {2'b10, 11'd0, 11'd0, 32'h2000}) begin
      failures++;
      $display("FAIL hold_first_offer got v=%b x=%0d y=%0d a=%h want v=10 (0,0) 2000",
               job_valid, job_x, job_y, job_addr);
    end
    job_ready = 2'b00;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) job_ready = 2'b01;
      @(negedge clk);
      checks++;
      if ({job_valid, job_x, job_y, job_addr} !== {2'b10, 11'd0, 11'd0, 32'h2000}) begin
        failures++;
        $display("FAIL hold_cycle%0d got v=%b x=%0d y=%0d a=%h want v=10 (0,0) 2000",
                 c, job_valid, job_x, job_y, job_addr);
      end
    end
    drain_frame(2'b11, 2, nj, nf, er, ea);
    checks++;
    if ({obs_v[0], obs_v[1], obs_x[1], obs_a[1]} !== {2'b10, 2'b01, 11'd1, 32'h2002}) begin
      failures++;
      $display("FAIL hold_sequence got v0=%b v1=%b x1=%0d a1=%h want 10 01 1 2002",
               obs_v[0], obs_v[1], obs_x[1], obs_a[1]);
    end
    checks++;
    if (nj !== 2 || nf !== 1) begin
      failures++;
      $display("FAIL hold_complete got jobs=%0d pulses=%0d want 2 1", nj, nf);
    end
  endtask

  task automatic test_empty_frame();
    int busy_cnt, fd_cnt, v_cnt;
    busy_cnt = 0; fd_cnt = 0; v_cnt = 0;
    job_ready = 2'b11;
    start_frame(11'd0, 11'd7, 32'h7000);
    for (int c = 0; c < 6; c++) begin
      if (busy === 1'b1) busy_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
      if (job_valid !== 2'b00) v_cnt++;
      @(negedge clk);
    end
    checks++;
    if (busy_cnt !== 2) begin failures++; $display("FAIL empty_busy got %0d cycles want 2", busy_cnt); end
    checks++;
    if (fd_cnt !== 1) begin failures++; $display("FAIL empty_done got %0d pulses want 1", fd_cnt); end
    checks++;
    if (v_cnt !== 0) begin failures++; $display("FAIL empty_valid got %0d offers want 0", v_cnt); end
  endtask

  task automatic test_async_reset();
    int seen, nj, nf, er, ea;
    seen = 0;
    job_ready = 2'b11;
    start_frame(11'd3, 11'd2, 32'h3000);
    for (int c = 0; c < 40 && seen < 3; c++) begin
      if (job_valid !== 2'b00) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 3 || {job_x, job_y, job_addr} !== {11'd0, 11'd1, 32'h3006}) begin
      failures++;
      $display("FAIL arst_progress got seen=%0d x=%0d y=%0d a=%h want 3 (0,1) 3006",
               seen, job_x, job_y, job_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({job_valid, job_x, job_y, job_addr, busy, frame_done} !== '0) begin
      failures++;
      $display("FAIL arst_outputs got v=%b x=%0d y=%0d a=%h busy=%b fd=%b want all 0",
               job_valid, job_x, job_y, job_addr, busy, frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    start_frame(11'd3, 11'd1, 32'h4000);
    drain_frame(2'b11, 3, nj, nf, er, ea);
    checks++;
    if ({obs_v[0], obs_x[0], obs_y[0], obs_a[0]} !== {2'b01, 11'd0, 11'd0, 32'h4000}) begin
      failures++;
      $display("FAIL arst_restart got v=%b x=%0d y=%0d a=%h want 01 (0,0) 4000",
               obs_v[0], obs_x[0], obs_y[0], obs_a[0]);
    end
    checks++;
    if (nj !== 3 || nf !== 1 || obs_a[2] !== 32'h4004) begin
      failures++;
      $display("FAIL arst_frame got jobs=%0d pulses=%0d a2=%h want 3 1 4004", nj, nf, obs_a[2]);
    end
  endtask

  task automatic test_spurious();
    int nj, nf, er, ea;
    checks++;
    if (err_spurious !== 1'b0) begin
      failures++;
      $display("FAIL spur_before got %b want 0", err_spurious);
    end
    pix_done = 1'b1;
    @(negedge clk);
    pix_done = 1'b0;
    checks++;
    if (err_spurious !== 1'b1) begin
      failures++;
      $display("FAIL spur_set got %b want 1", err_spurious);
    end
    job_ready = 2'b11;
    start_frame(11'd1, 11'd1, 32'h6000);
    drain_frame(2'b11, 1, nj, nf, er, ea);
    checks++;
    if (ea !== 1 || err_spurious !== 1'b1) begin
      failures++;
      $display("FAIL spur_sticky got all_cycles=%0d now=%b want 1 1", ea, err_spurious);
    end
    checks++;
    if (nj !== 1 || nf !== 1 || {obs_v[0], obs_a[0]} !== {2'b10, 32'h6000}) begin
      failures++;
      $display("FAIL spur_frame got jobs=%0d pulses=%0d v=%b a=%h want 1 1 10 6000",
               nj, nf, obs_v[0], obs_a[0]);
    end
  endtask

  task automatic test_start_while_busy();
    int nj, nf, er, ea;
    job_ready = 2'b11;
    start_frame(11'd3, 11'd1, 32'h5000);
    cfg_w = 11'd5; cfg_h = 11'd5; cfg_base = 32'h9000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain_frame(2'b11, 3, nj, nf, er, ea);
    checks++;
    if (nj !== 3 || nf !== 1) begin
      failures++;
      $display("FAIL busy_start_count got jobs=%0d pulses=%0d want 3 1", nj, nf);
    end
    checks++;
    if ({obs_x[0], obs_a[0], obs_x[1], obs_a[1], obs_x[2], obs_y[2], obs_a[2]} !==
        {11'd0, 32'h5000, 11'd1, 32'h5002, 11'd2, 11'd0, 32'h5004}) begin
      failures++;
      $display("FAIL busy_start_seq got a0=%h a1=%h a2=%h x2=%0d y2=%0d want 5000 5002 5004 2 0",
               obs_a[0], obs_a[1], obs_a[2], obs_x[2], obs_y[2]);
    end
    checks++;
    if ({obs_v[0], obs_v[1], obs_v[2]} !== 6'b01_10_01) begin
      failures++;
      $display("FAIL busy_start_rr got %b %b %b want 01 10 01", obs_v[0], obs_v[1], obs_v[2]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_offer_hold();
    test_empty_frame();
    test_async_reset();
    test_spurious();
    test_start_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
